// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipe_shift_ctrl delay chain.
package pipe_pkg;

   localparam int unsigned RD_ZERO = 0;

   typedef enum logic [1:0] {SHIFT, STALL, FLUSH} stage_cmd_e;

   // flush dominates stall: killed entries never need to be held
   function automatic stage_cmd_e decode_cmd(input logic stall, input logic flush);
      if (flush) begin
         return FLUSH;
      end else if (stall) begin
         return STALL;
      end
      return SHIFT;
   endfunction

   function automatic logic [3:0] popcount(input logic [7:0] v);
      logic [3:0] cnt;
      cnt = '0;
      for (int i = 0; i < 8; i++) begin
         cnt = cnt + {3'b000, v[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/pipe_match.sv
// Youngest-writer priority encoder for one hazard query port.
// PIPE_SHIFT_FWD_DATA_EN adds the forwarded payload of the matching stage.
module pipe_match
   import pipe_pkg::*;
#(
   parameter int unsigned DEPTH = 3,
   parameter int unsigned RD_W  = 5
`ifdef PIPE_SHIFT_FWD_DATA_EN
   ,
   parameter int unsigned WIDTH = 32
`endif
) (
   input  logic [DEPTH-1:0]                valid,
   input  logic [DEPTH-1:0]                wen,
   input  logic [DEPTH-1:0][RD_W-1:0]      rd,
`ifdef PIPE_SHIFT_FWD_DATA_EN
   input  logic [DEPTH-1:0][WIDTH-1:0]     data,
   output logic [WIDTH-1:0]                q_data,
`endif
   input  logic [RD_W-1:0]                 q_rs,
   output logic                            hit,
   output logic [$clog2(DEPTH)-1:0]        stage
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   // Scan oldest to youngest so the last match written is the smallest index.
   always_comb begin
      hit   = 1'b0;
      stage = '0;
`ifdef PIPE_SHIFT_FWD_DATA_EN
      q_data = '0;
`endif
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
         if (valid[k] && wen[k] && (rd[k] == q_rs) && (q_rs != RD_W'(RD_ZERO))) begin
            hit   = 1'b1;
            stage = IDX_W'(k);
`ifdef PIPE_SHIFT_FWD_DATA_EN
            q_data = data[k];
`endif
         end
      end
   end

endmodule

// File: rtl/pipe_shift_ctrl.sv
// Decode-to-writeback delay chain with stall bubbles, flush and hazard lookup.
// Optional PIPE_SHIFT_FWD_DATA_EN adds the q_data forwarding port.
module pipe_shift_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned DEPTH       = 3,
   parameter int unsigned RD_W        = 5,
   parameter int unsigned NQ          = 2,
   parameter int unsigned FLUSH_DEPTH = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   input  logic [WIDTH-1:0]                  in_data,
   input  logic [RD_W-1:0]                   in_rd,
   input  logic                              in_wen,
   output logic                              in_ready,
   input  logic                              stall,
   input  logic                              flush,
   output logic                              out_valid,
   output logic [WIDTH-1:0]                  out_data,
   output logic [RD_W-1:0]                   out_rd,
   output logic                              out_wen,
   input  logic [NQ*RD_W-1:0]                q_rs,
   output logic [NQ-1:0]                     q_hit,
   output logic [NQ*$clog2(DEPTH)-1:0]       q_stage,
   output logic [$clog2(DEPTH+1)-1:0]        occupancy
`ifdef PIPE_SHIFT_FWD_DATA_EN
   ,
   output logic [NQ*WIDTH-1:0]               q_data
`endif
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0]             valid_q, valid_d;
   logic [DEPTH-1:0]             wen_q, wen_d;
   logic [DEPTH-1:0][RD_W-1:0]   rd_q, rd_d;
   logic [DEPTH-1:0][WIDTH-1:0]  data_q, data_d;
   stage_cmd_e                   cmd;
   logic [7:0]                   valid_ext;

   assign cmd      = decode_cmd(stall, flush);
   assign in_ready = !stall || flush;

   always_comb begin
      valid_d = valid_q;
      wen_d   = wen_q;
      rd_d    = rd_q;
      data_d  = data_q;
      unique case (cmd)
         SHIFT: begin
            valid_d[0] = in_valid;
            data_d[0]  = in_data;
            rd_d[0]    = in_rd;
            wen_d[0]   = in_wen;
            for (int k = 1; k < int'(DEPTH); k++) begin
               valid_d[k] = valid_q[k-1];
               data_d[k]  = data_q[k-1];
               rd_d[k]    = rd_q[k-1];
               wen_d[k]   = wen_q[k-1];
            end
         end
         STALL: begin
            // stage 0 holds; the slot it would have filled becomes a bubble
            valid_d[1] = 1'b0;
            data_d[1]  = '0;
            rd_d[1]    = '0;
            wen_d[1]   = 1'b0;
            for (int k = 2; k < int'(DEPTH); k++) begin
               valid_d[k] = valid_q[k-1];
               data_d[k]  = data_q[k-1];
               rd_d[k]    = rd_q[k-1];
               wen_d[k]   = wen_q[k-1];
            end
         end
         FLUSH: begin
            valid_d[0] = 1'b0;
            data_d[0]  = '0;
            rd_d[0]    = '0;
            wen_d[0]   = 1'b0;
            for (int k = 1; k < int'(DEPTH); k++) begin
               if ((k - 1) < int'(FLUSH_DEPTH)) begin
                  valid_d[k] = 1'b0;
                  data_d[k]  = '0;
                  rd_d[k]    = '0;
                  wen_d[k]   = 1'b0;
               end else begin
                  valid_d[k] = valid_q[k-1];
                  data_d[k]  = data_q[k-1];
                  rd_d[k]    = rd_q[k-1];
                  wen_d[k]   = wen_q[k-1];
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         wen_q   <= '0;
         rd_q    <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         wen_q   <= wen_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_data  = data_q[DEPTH-1];
   assign out_rd    = rd_q[DEPTH-1];
   assign out_wen   = valid_q[DEPTH-1] & wen_q[DEPTH-1];

   always_comb begin
      valid_ext              = '0;
      valid_ext[DEPTH-1:0]   = valid_q;
      occupancy              = OCC_W'(popcount(valid_ext));
   end

   for (genvar i = 0; i < NQ; i++) begin : g_query
      pipe_match #(
         .DEPTH (DEPTH),
         .RD_W  (RD_W)
`ifdef PIPE_SHIFT_FWD_DATA_EN
         ,
         .WIDTH (WIDTH)
`endif
      ) u_match (
         .valid  (valid_q),
         .wen    (wen_q),
         .rd     (rd_q),
`ifdef PIPE_SHIFT_FWD_DATA_EN
         .data   (data_q),
         .q_data (q_data[i*WIDTH +: WIDTH]),
`endif
         .q_rs   (q_rs[i*RD_W +: RD_W]),
         .hit    (q_hit[i]),
         .stage  (q_stage[i*IDX_W +: IDX_W])
      );
   end

endmodule
